// File: rtl/vec_exec_if.sv
// ============================================================================
// Module   : vec_exec_if
// Brief    : Decode->execute pipeline register view plus writeback beat for
//            the vector execute unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vec_exec_if #(
    parameter int VEC_W = 64
);
    logic             flush;
    logic [4:0]       q_opcode;
    logic [31:0]      q_reg1_data;
    logic [7:0]       q_immediate;
    logic [VEC_W-1:0] q_vec1_data;
    logic [VEC_W-1:0] q_vec2_data;
    logic [2:0]       q_wb_register;
    logic             stall;
    logic             busy;
    logic             wb_valid;
    logic [2:0]       wb_register;
    logic [VEC_W-1:0] wb_data;
    logic             illegal_op;

    modport master (
        output flush, q_opcode, q_reg1_data, q_immediate, q_vec1_data,
               q_vec2_data, q_wb_register,
        input  stall, busy, wb_valid, wb_register, wb_data, illegal_op
    );

    modport slave (
        input  flush, q_opcode, q_reg1_data, q_immediate, q_vec1_data,
               q_vec2_data, q_wb_register,
        output stall, busy, wb_valid, wb_register, wb_data, illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/vec_exec_unit.sv
// ============================================================================
// Module   : vec_exec_unit
// Brief    : Multi-cycle lane-wise vector execute stage, LANES_PER_CYCLE lanes
//            per cycle, single registered writeback beat. Optional macro
//            VEC_SAT_EN selects unsigned saturation for VADD/VADDI/VSUB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_exec_unit #(
    parameter int LANES           = 8,
    parameter int LANE_W          = 8,
    parameter int LANES_PER_CYCLE = 2
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    vec_exec_if.slave   bus
);
    localparam int VEC_W = LANES * LANE_W;
    localparam int N     = LANES / LANES_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [4:0] c_OP_VADD  = 5'b00001;
    localparam logic [4:0] c_OP_VSUB  = 5'b00010;
    localparam logic [4:0] c_OP_VMUL  = 5'b00011;
    localparam logic [4:0] c_OP_VADDI = 5'b00100;
    localparam logic [4:0] c_OP_VSHL  = 5'b00101;
    localparam logic [4:0] c_OP_NOP   = 5'b11110;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (LANES % LANES_PER_CYCLE != 0) begin : g_bad_lane_split
            $error("vec_exec_unit: LANES must be a multiple of LANES_PER_CYCLE");
        end
        if (VEC_W != 64) begin : g_bad_vec_width
            $error("vec_exec_unit: LANES*LANE_W must match the 64-bit bus");
        end
    endgenerate

    typedef logic [LANE_W-1:0] lane_t;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_chunk;
    logic [VEC_W-1:0] r_partial;
    logic [4:0]       r_opc;
    logic [VEC_W-1:0] r_a;
    logic [VEC_W-1:0] r_b;
    logic [7:0]       r_imm;
    logic [2:0]       r_sh;
    logic [2:0]       r_dst;
    logic             r_wb_valid;
    logic [2:0]       r_wb_register;
    logic [VEC_W-1:0] r_wb_data;
    logic             r_illegal;

    logic             w_legal;
    logic             w_nop;
    logic             w_accept;
    logic             w_illegal;
    logic             w_last;
    logic [VEC_W-1:0] w_next;
    int               w_lane;

    function automatic lane_t f_lane(input logic [4:0] op, input lane_t a,
                                     input lane_t b, input lane_t imm,
                                     input logic [2:0] sh);
        logic [LANE_W:0]     s;
        logic [2*LANE_W-1:0] p;
        lane_t               r;
        s = '0;
        p = '0;
        r = '0;
        case (op)
            c_OP_VADD, c_OP_VADDI: begin
                s = {1'b0, a} + {1'b0, (op == c_OP_VADD) ? b : imm};
`ifdef VEC_SAT_EN
                r = s[LANE_W] ? '1 : s[LANE_W-1:0];
`else
                r = s[LANE_W-1:0];
`endif
            end
            c_OP_VSUB: begin
                s = {1'b0, a} - {1'b0, b};
                // s[LANE_W] is the borrow out of the lane subtraction
`ifdef VEC_SAT_EN
                r = s[LANE_W] ? '0 : s[LANE_W-1:0];
`else
                r = s[LANE_W-1:0];
`endif
            end
            c_OP_VMUL: begin
                p = a * b;
                r = p[LANE_W-1:0];
            end
            c_OP_VSHL: r = a << sh;
            default:   r = '0;
        endcase
        return r;
    endfunction

    assign w_legal   = (bus.q_opcode >= c_OP_VADD) && (bus.q_opcode <= c_OP_VSHL);
    assign w_nop     = (bus.q_opcode == c_OP_NOP);
    assign w_accept  = (r_state == S_IDLE) && w_legal && !bus.flush;
    assign w_illegal = (r_state == S_IDLE) && !w_legal && !w_nop;
    assign w_last    = (r_chunk == CNT_W'(N - 1));

    // Merge the lanes of the current chunk into the running partial result.
    always_comb begin
        w_next = r_partial;
        w_lane = 0;
        for (int k = 0; k < LANES_PER_CYCLE; k++) begin
            w_lane = int'(r_chunk) * LANES_PER_CYCLE + k;
            w_next[w_lane*LANE_W +: LANE_W] = f_lane(r_opc,
                r_a[w_lane*LANE_W +: LANE_W], r_b[w_lane*LANE_W +: LANE_W],
                lane_t'(r_imm), r_sh);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_chunk       <= '0;
            r_partial     <= '0;
            r_opc         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_imm         <= '0;
            r_sh          <= '0;
            r_dst         <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_register <= '0;
            r_wb_data     <= '0;
            r_illegal     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_illegal  <= w_illegal;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opc   <= bus.q_opcode;
                        r_a     <= bus.q_vec1_data;
                        r_b     <= bus.q_vec2_data;
                        r_imm   <= bus.q_immediate;
                        r_sh    <= bus.q_reg1_data[2:0];
                        r_dst   <= bus.q_wb_register;
                        r_chunk <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        r_chunk <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_partial <= w_next;
                        if (w_last) begin
                            r_chunk       <= '0;
                            r_wb_data     <= w_next;
                            r_wb_register <= r_dst;
                            r_wb_valid    <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_chunk <= r_chunk + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall       = w_accept || (r_state == S_RUN);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_register = r_wb_register;
    assign bus.wb_data     = r_wb_data;
    assign bus.illegal_op  = r_illegal;
endmodule

`default_nettype wire

// File: tb/tb_vec_exec_unit.sv
// ============================================================================
// Module   : tb_vec_exec_unit
// Brief    : Self-checking bench for vec_exec_unit against a lane-arithmetic
//            reference model (honours VEC_SAT_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_exec_unit;
    localparam int N = 4;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    vec_exec_if #(.VEC_W(64)) vif ();

    vec_exec_unit #(.LANES(8), .LANE_W(8), .LANES_PER_CYCLE(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [31:0] reg1,
                                          input logic [7:0] imm);
        logic [63:0] res;
        int x, y, r;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            x = int'(a[8*i +: 8]);
            y = int'(b[8*i +: 8]);
            r = 0;
            case (op)
                5'd1: r = x + y;
                5'd2: r = x - y;
                5'd3: r = (x * y) % 256;
                5'd4: r = x + int'(imm);
                5'd5: r = (x * (1 << reg1[2:0])) % 256;
                default: r = 0;
            endcase
`ifdef VEC_SAT_EN
            if (r > 255) r = 255;
            if (r < 0) r = 0;
`else
            r = (r + 256) % 256;
`endif
            res[8*i +: 8] = 8'(r);
        end
        return res;
    endfunction

    task automatic drive_idle();
        vif.flush         = 1'b0;
        vif.q_opcode      = 5'b11110;
        vif.q_reg1_data   = '0;
        vif.q_immediate   = '0;
        vif.q_vec1_data   = '0;
        vif.q_vec2_data   = '0;
        vif.q_wb_register = '0;
    endtask

    // Present one op at a negedge; the following posedge is the accept edge.
    task automatic present(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [31:0] reg1, input logic [7:0] imm, input logic [2:0] dst);
        @(negedge clk);
        vif.q_opcode      = op;
        vif.q_vec1_data   = a;
        vif.q_vec2_data   = b;
        vif.q_reg1_data   = reg1;
        vif.q_immediate   = imm;
        vif.q_wb_register = dst;
        #1 chk("stall_at_accept", 64'(vif.stall), 64'd1);
    endtask

    task automatic do_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [31:0] reg1, input logic [7:0] imm, input logic [2:0] dst);
        logic [63:0] exp;
        exp = model(op, a, b, reg1, imm);
        present(op, a, b, reg1, imm, dst);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("run_stall", 64'(vif.stall), 64'd1);
            chk("run_no_wb", 64'(vif.wb_valid), 64'd0);
            vif.q_opcode      = 5'(1 + $urandom_range(0, 4));
            vif.q_vec1_data   = {$urandom, $urandom};
            vif.q_vec2_data   = {$urandom, $urandom};
            vif.q_reg1_data   = $urandom;
            vif.q_immediate   = 8'($urandom);
            vif.q_wb_register = 3'($urandom);
            @(negedge clk);
        end
        vif.q_opcode = 5'b11110;
        #1;
        chk("done_wb_valid", 64'(vif.wb_valid), 64'd1);
        chk("done_wb_data", vif.wb_data, exp);
        chk("done_wb_reg", 64'(vif.wb_register), 64'(dst));
        chk("done_stall_low", 64'(vif.stall), 64'd0);
        @(negedge clk);
        chk("post_wb_valid", 64'(vif.wb_valid), 64'd0);
        chk("post_busy", 64'(vif.busy), 64'd0);
        chk("post_wb_hold", vif.wb_data, exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", 64'(vif.wb_valid), 64'd0);
        chk("rst_wb_data", vif.wb_data, 64'd0);
        chk("rst_wb_reg", 64'(vif.wb_register), 64'd0);
        chk("rst_busy", 64'(vif.busy), 64'd0);
        chk("rst_illegal", 64'(vif.illegal_op), 64'd0);
        reset_n = 1'b1;

        do_op(5'd1, 64'h0102030405060708, 64'h1010101010101010, 32'h0, 8'h0, 3'd3);
        do_op(5'd1, 64'h00000000000000FF, 64'h0000000000000001, 32'h0, 8'h0, 3'd1);
        do_op(5'd2, 64'h0000000000000000, 64'h0000000000000001, 32'h0, 8'h0, 3'd2);
        do_op(5'd3, 64'h0000000000000010, 64'h0000000000000011, 32'h0, 8'h0, 3'd4);
        do_op(5'd5, 64'h0000000000000081, 64'h0, 32'h3, 8'h0, 3'd5);
        do_op(5'd4, 64'h0, 64'h0, 32'h0, 8'h05, 3'd6);
        do_op(5'd4, 64'hFAFBFCFDFEFF0001, 64'h0, 32'h0, 8'h05, 3'd7);

        for (int i = 0; i < 16; i++)
            do_op(5'(1 + $urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom, 8'($urandom), 3'($urandom));

        // Flush in RUN: op abandoned, no writeback ever appears.
        present(5'd1, 64'h1, 64'h1, 32'h0, 8'h0, 3'd2);
        @(negedge clk);
        vif.q_opcode = 5'b11110;
        @(negedge clk);
        vif.flush = 1'b1;
        #1 chk("flush_stall_in_run", 64'(vif.stall), 64'd1);
        @(negedge clk);
        vif.flush = 1'b0;
        #1;
        chk("flush_busy", 64'(vif.busy), 64'd0);
        chk("flush_stall", 64'(vif.stall), 64'd0);
        for (int k = 0; k < N + 2; k++) begin
            chk("flush_no_wb", 64'(vif.wb_valid), 64'd0);
            @(negedge clk);
        end

        // Flush in IDLE suppresses the accept.
        @(negedge clk);
        vif.flush    = 1'b1;
        vif.q_opcode = 5'd1;
        #1 chk("flush_idle_stall", 64'(vif.stall), 64'd0);
        @(negedge clk);
        chk("flush_idle_busy", 64'(vif.busy), 64'd0);
        drive_idle();

        // Asynchronous reset mid-operation.
        present(5'd2, 64'hFFFF, 64'h1111, 32'h0, 8'h0, 3'd5);
        repeat (2) @(negedge clk);
        vif.q_opcode = 5'b11110;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(vif.busy), 64'd0);
        chk("arst_wb_data", vif.wb_data, 64'd0);
        chk("arst_wb_reg", 64'(vif.wb_register), 64'd0);
        chk("arst_stall", 64'(vif.stall), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            chk("arst_no_wb", 64'(vif.wb_valid), 64'd0);
            @(negedge clk);
        end
        do_op(5'd1, 64'h0102030405060708, 64'h1010101010101010, 32'h0, 8'h0, 3'd3);

        // Illegal opcode pulses once, never stalls or writes back; NOP is silent.
        @(negedge clk);
        vif.q_opcode = 5'b01111;
        #1 chk("illegal_stall", 64'(vif.stall), 64'd0);
        @(negedge clk);
        vif.q_opcode = 5'b11110;
        chk("illegal_pulse", 64'(vif.illegal_op), 64'd1);
        chk("illegal_busy", 64'(vif.busy), 64'd0);
        @(negedge clk);
        chk("illegal_clear", 64'(vif.illegal_op), 64'd0);
        chk("illegal_no_wb", 64'(vif.wb_valid), 64'd0);
        #1 chk("nop_stall", 64'(vif.stall), 64'd0);
        @(negedge clk);
        chk("nop_no_illegal", 64'(vif.illegal_op), 64'd0);
        chk("nop_busy", 64'(vif.busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
